// File: rtl/dense_layer_sequencer.sv
// Per-sample sequencer for the dense decode register stage: weight row load,
// forward layer sweep, then (training only) cost backprop and backward updates.
module dense_layer_sequencer #(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int cnt_size  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      train,
  input  logic [cnt_size-1:0]       num_layers,
  input  logic [cnt_size-1:0]       num_rows,
  input  logic [data_size*size-1:0] w_in,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [data_size*size-1:0] w,
  output logic [31:0]               w_layer_index,
  output logic [31:0]               w_row_index,
  output logic                      load_w,
  output logic                      layer_step,
  output logic                      is_cost_layer,
  output logic                      backprop_cost,
  output logic                      is_update,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FWD  = 3'd2,
    ST_COST = 3'd3,
    ST_BWD  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t              state_r;
  logic [cnt_size-1:0] layer_r;
  logic [cnt_size-1:0] row_r;
  logic [cnt_size-1:0] last_layer_r;
  logic [cnt_size-1:0] last_row_r;
  logic                train_r;

  // Decoded straight from the state register, so both are glitch-free.
  assign w_ready = (state_r == ST_LOAD);
  assign busy    = (state_r != ST_IDLE);

  // Sequencer FSM with registered strobes, indices and weight row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      layer_r       <= {cnt_size{1'b0}};
      row_r         <= {cnt_size{1'b0}};
      last_layer_r  <= {cnt_size{1'b0}};
      last_row_r    <= {cnt_size{1'b0}};
      train_r       <= 1'b0;
      w             <= {(data_size*size){1'b0}};
      w_layer_index <= 32'd0;
      w_row_index   <= 32'd0;
      load_w        <= 1'b0;
      layer_step    <= 1'b0;
      is_cost_layer <= 1'b0;
      backprop_cost <= 1'b0;
      is_update     <= 1'b0;
      done          <= 1'b0;
    end else begin
      load_w        <= 1'b0;
      layer_step    <= 1'b0;
      is_cost_layer <= 1'b0;
      backprop_cost <= 1'b0;
      is_update     <= 1'b0;
      done          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            train_r      <= train;
            last_layer_r <= num_layers - cnt_size'(1);
            last_row_r   <= num_rows - cnt_size'(1);
            layer_r      <= {cnt_size{1'b0}};
            row_r        <= {cnt_size{1'b0}};
            // An empty network completes immediately without leaving IDLE.
            if ((num_layers == {cnt_size{1'b0}}) || (num_rows == {cnt_size{1'b0}})) begin
              done <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_valid) begin
            w             <= w_in;
            load_w        <= 1'b1;
            w_layer_index <= 32'(layer_r);
            w_row_index   <= 32'(row_r);
            if (row_r == last_row_r) begin
              row_r <= {cnt_size{1'b0}};
              if (layer_r == last_layer_r) begin
                layer_r <= {cnt_size{1'b0}};
                state_r <= ST_FWD;
              end else begin
                layer_r <= layer_r + cnt_size'(1);
              end
            end else begin
              row_r <= row_r + cnt_size'(1);
            end
          end
        end
        ST_FWD: begin
          layer_step    <= 1'b1;
          w_layer_index <= 32'(layer_r);
          w_row_index   <= 32'd0;
          if (layer_r == last_layer_r) begin
            is_cost_layer <= train_r;
            state_r       <= train_r ? ST_COST : ST_DONE;
          end else begin
            layer_r <= layer_r + cnt_size'(1);
          end
        end
        ST_COST: begin
          backprop_cost <= 1'b1;
          w_layer_index <= 32'(last_layer_r);
          w_row_index   <= 32'd0;
          layer_r       <= last_layer_r;
          state_r       <= ST_BWD;
        end
        ST_BWD: begin
          is_update     <= 1'b1;
          w_layer_index <= 32'(layer_r);
          w_row_index   <= 32'd0;
          if (layer_r == {cnt_size{1'b0}}) begin
            state_r <= ST_DONE;
          end else begin
            layer_r <= layer_r - cnt_size'(1);
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: operation-queue reference model compared
// every cycle, directed cases with hand-computed expectations, random samples.
module tb_dense_layer_sequencer;

  localparam int SIZE = 3;
  localparam int DS   = 16;
  localparam int CS   = 8;
  localparam int WW   = DS * SIZE;

  localparam int K_LOAD = 0;
  localparam int K_STEP = 1;
  localparam int K_COST = 2;
  localparam int K_UPD  = 3;
  localparam int K_DONE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          train = 1'b0;
  logic [CS-1:0] num_layers = '0;
  logic [CS-1:0] num_rows = '0;
  logic [WW-1:0] w_in = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [WW-1:0] w;
  logic [31:0]   w_layer_index;
  logic [31:0]   w_row_index;
  logic          load_w, layer_step, is_cost_layer, backprop_cost, is_update, busy, done;

  dense_layer_sequencer #(.size(SIZE), .data_size(DS), .cnt_size(CS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train(train),
    .num_layers(num_layers), .num_rows(num_rows), .w_in(w_in), .w_valid(w_valid),
    .w_ready(w_ready), .w(w), .w_layer_index(w_layer_index), .w_row_index(w_row_index),
    .load_w(load_w), .layer_step(layer_step), .is_cost_layer(is_cost_layer),
    .backprop_cost(backprop_cost), .is_update(is_update), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a sample is a queue of operations, one retired per cycle
  // (loads only when a beat is offered).
  typedef struct {int kind; int layer; int row; bit cl;} op_t;
  op_t q[$];
  logic [WW-1:0] m_w;
  int  m_li, m_ri;
  bit  m_load, m_step, m_cl, m_cost, m_upd, m_done;

  function automatic op_t mk(input int k, input int l, input int r, input bit c);
    op_t o;
    o.kind = k; o.layer = l; o.row = r; o.cl = c;
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_w = '0; m_li = 0; m_ri = 0;
      m_load = 0; m_step = 0; m_cl = 0; m_cost = 0; m_upd = 0; m_done = 0;
    end else begin
      m_load = 0; m_step = 0; m_cl = 0; m_cost = 0; m_upd = 0; m_done = 0;
      if (q.size() == 0) begin
        if (start) begin
          int nl, nr;
          nl = int'(num_layers);
          nr = int'(num_rows);
          if (nl == 0 || nr == 0) m_done = 1;
          else begin
            for (int l = 0; l < nl; l++)
              for (int r = 0; r < nr; r++) q.push_back(mk(K_LOAD, l, r, 0));
            for (int l = 0; l < nl; l++) q.push_back(mk(K_STEP, l, 0, train && (l == nl - 1)));
            if (train) begin
              q.push_back(mk(K_COST, nl - 1, 0, 0));
              for (int l = nl - 1; l >= 0; l--) q.push_back(mk(K_UPD, l, 0, 0));
            end
            q.push_back(mk(K_DONE, 0, 0, 0));
          end
        end
      end else begin
        op_t h;
        h = q[0];
        if (h.kind == K_LOAD) begin
          if (w_valid) begin
            m_w = w_in; m_load = 1; m_li = h.layer; m_ri = h.row;
            void'(q.pop_front());
          end
        end else begin
          if (h.kind == K_STEP) begin m_step = 1; m_cl = h.cl; m_li = h.layer; m_ri = 0; end
          if (h.kind == K_COST) begin m_cost = 1; m_li = h.layer; m_ri = 0; end
          if (h.kind == K_UPD)  begin m_upd = 1; m_li = h.layer; m_ri = 0; end
          if (h.kind == K_DONE) m_done = 1;
          void'(q.pop_front());
        end
      end
    end
  end

  // Per-sample observation log used by the directed literal checks.
  int ld_log[$];
  int up_log[$];
  int n_step, n_cl, n_cost;

  always @(negedge clk) begin
    chk("w", w, m_w);
    chk("w_layer_index", w_layer_index, m_li);
    chk("w_row_index", w_row_index, m_ri);
    chk("load_w", load_w, m_load);
    chk("layer_step", layer_step, m_step);
    chk("is_cost_layer", is_cost_layer, m_cl);
    chk("backprop_cost", backprop_cost, m_cost);
    chk("is_update", is_update, m_upd);
    chk("done", done, m_done);
    chk("busy", busy, q.size() > 0);
    chk("w_ready", w_ready, (q.size() > 0) && (q[0].kind == K_LOAD));
    chk("strobe_excl", (int'(load_w) + int'(layer_step) + int'(backprop_cost) + int'(is_update)) <= 1, 1);
    if (load_w) ld_log.push_back(int'(w_layer_index) * 256 + int'(w_row_index));
    if (is_update) up_log.push_back(int'(w_layer_index));
    n_step += int'(layer_step);
    n_cl   += int'(is_cost_layer);
    n_cost += int'(backprop_cost);
  end

  function automatic bit vpat(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 2) == 1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Runs one sample; exp_cyc < 0 skips the cycle-count literal.
  task automatic run_sample(input int nl, input int nr, input bit tr, input int vmode,
                            input bit reissue, input int exp_cyc);
    int  cyc;
    bit  found;
    ld_log.delete(); up_log.delete();
    n_step = 0; n_cl = 0; n_cost = 0;
    @(posedge clk); #2;
    num_layers = CS'(nl); num_rows = CS'(nr); train = tr; start = 1'b1;
    w_valid = vpat(vmode, 1); w_in = WW'({$urandom, $urandom});
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 1; found = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) begin found = 1; break; end
      @(posedge clk); #2;
      cyc++;
      w_valid = vpat(vmode, cyc);
      w_in = WW'({$urandom, $urandom});
      if (reissue) begin
        start = $urandom_range(0, 1) == 1;
        num_layers = CS'($urandom); num_rows = CS'($urandom); train = $urandom_range(0, 1) == 1;
      end
    end
    start = 1'b0;
    chk("done_seen", found, 1);
    if (exp_cyc >= 0) chk("cycles", cyc, exp_cyc);
  endtask

  int t1_exp[6] = '{0, 1, 2, 256, 257, 258};

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: L=2 R=3 inference
    run_sample(2, 3, 1'b0, 0, 1'b0, 10);
    chk("t1_nloads", ld_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_load_idx", (i < ld_log.size()) ? ld_log[i] : -1, t1_exp[i]);
    chk("t1_steps", n_step, 2);
    chk("t1_cost_layer", n_cl, 0);

    // 2: L=2 R=2 training
    run_sample(2, 2, 1'b1, 0, 1'b0, 11);
    chk("t2_nloads", ld_log.size(), 4);
    chk("t2_steps", n_step, 2);
    chk("t2_cost_layer", n_cl, 1);
    chk("t2_backprop", n_cost, 1);
    chk("t2_nupd", up_log.size(), 2);
    chk("t2_upd0", (up_log.size() > 0) ? up_log[0] : -1, 1);
    chk("t2_upd1", (up_log.size() > 1) ? up_log[1] : -1, 0);

    // 3: toggled w_valid
    run_sample(1, 3, 1'b0, 1, 1'b0, 8);
    chk("t3_nloads", ld_log.size(), 3);

    // 4: empty network
    run_sample(0, 3, 1'b1, 0, 1'b0, 1);
    run_sample(4, 0, 1'b0, 0, 1'b0, 1);
    chk("t4_nloads", ld_log.size(), 0);

    // 5: start re-pulsed while busy
    run_sample(2, 3, 1'b1, 0, 1'b1, 1 + 6 + 2 + 1 + 2 + 1);
    run_sample(3, 2, 1'b0, 2, 1'b1, -1);

    // 6: reset during first backward step
    @(posedge clk); #2;
    num_layers = 8'd3; num_rows = 8'd1; train = 1'b1; w_valid = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("t6_in_bwd", is_update, 1);
    chk("t6_bwd_layer", w_layer_index, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {w, w_layer_index, w_row_index}, 0);
    chk("t6_rst_strobes", {load_w, layer_step, is_cost_layer, backprop_cost, is_update, done}, 0);
    chk("t6_rst_busy", {busy, w_ready}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_sample(3, 2, 1'b1, 0, 1'b0, 15);

    // counter extremes
    run_sample(255, 1, 1'b1, 0, 1'b0, 1 + 255 + 255 + 1 + 255 + 1);
    run_sample(1, 255, 1'b0, 0, 1'b0, 1 + 255 + 1 + 1);

    // random samples
    for (int i = 0; i < 25; i++)
      run_sample($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(0, 1) == 1,
                 2, $urandom_range(0, 1) == 1, -1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
